// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and divisor==1 skip the iteration loop.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE_VAL = DATA_WIDTH'(1);

    // S_LOAD converts the captured operands to magnitudes before the loop starts.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              op_q;
    logic [DATA_WIDTH-1:0]   dividend_q, divisor_q;
    logic [DATA_WIDTH-1:0]   dvs_q, quo_q, rem_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    accept, early_out, is_signed;
    logic [DATA_WIDTH:0]     rem_shift, rem_diff;
    logic [DATA_WIDTH-1:0]   rem_nxt, quo_nxt;

    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v,
                                                      input logic              sgn);
        logic signed [DATA_WIDTH-1:0] sv;
        sv = $signed(v);
        if (sgn && sv < 0)
            return $unsigned(-sv);
        return v;
    endfunction

    // Applies the RV32M special cases and the sign rules to the unsigned quotient/remainder.
    function automatic logic [DATA_WIDTH-1:0] fix_result(input logic [1:0]            f_op,
                                                         input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b,
                                                         input logic [DATA_WIDTH-1:0] q,
                                                         input logic [DATA_WIDTH-1:0] r);
        logic                  sgn;
        logic [DATA_WIDTH-1:0] q_s, r_s;
        sgn = ~f_op[0];
        if (b == '0)
            return f_op[1] ? a : '1;
        if (sgn && a == MIN_VAL && b == '1)
            return f_op[1] ? '0 : MIN_VAL;
        q_s = (sgn && (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1])) ? $unsigned(-$signed(q)) : q;
        r_s = (sgn && a[DATA_WIDTH-1]) ? $unsigned(-$signed(r)) : r;
        return f_op[1] ? r_s : q_s;
    endfunction

    assign is_signed = ~op_q[0];
    assign accept    = (state == S_IDLE || state == S_DONE) && start && !kill;
    assign busy      = (state == S_CALC);
    assign done      = (state == S_DONE);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (divisor_q == '0) || (divisor_q == ONE_VAL) ||
                       (is_signed && dividend_q == MIN_VAL && divisor_q == '1);
`else
    assign early_out = 1'b0;
`endif

    // One restoring step: the shifted partial remainder needs one extra bit for the trial subtract.
    always_comb begin
        rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        if (!rem_diff[DATA_WIDTH]) begin
            rem_nxt = rem_diff[DATA_WIDTH-1:0];
            quo_nxt = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem_shift[DATA_WIDTH-1:0];
            quo_nxt = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_LOAD;
            S_LOAD: begin
                if (kill)           state_nxt = S_IDLE;
                else if (early_out) state_nxt = S_DONE;
                else                state_nxt = S_CALC;
            end
            S_CALC: begin
                if (kill)              state_nxt = S_IDLE;
                else if (cnt_q == '0)  state_nxt = S_DONE;
            end
            S_DONE: state_nxt = accept ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= op;
                dividend_q <= dividend;
                divisor_q  <= divisor;
            end
            if (state == S_LOAD && !kill) begin
                quo_q <= abs_val(dividend_q, is_signed);
                dvs_q <= abs_val(divisor_q, is_signed);
                rem_q <= '0;
                cnt_q <= CNT_W'(DATA_WIDTH - 1);
                if (early_out)
                    result <= fix_result(op_q, dividend_q, divisor_q,
                                         abs_val(dividend_q, is_signed), '0);
            end
            if (state == S_CALC && !kill) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == '0)
                    result <= fix_result(op_q, dividend_q, divisor_q, quo_nxt, rem_nxt);
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operations against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [1:0]  op;
    logic [31:0] dividend, divisor;
    logic        busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            OP_DIV:  return $unsigned(sa / sb);
            OP_DIVU: return a / b;
            OP_REM:  return $unsigned(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'd0 || b == 32'd1 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 2;
`endif
        return (o == 2'b00 && a == 32'd0 && b == 32'd0) ? 34 : 34;
    endfunction

    // Entered #1 after a rising edge with the DUT idle; returns #1 after the edge that leaves DONE.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cyc);
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        op       = 2'($urandom);
        lat = 999; busy_cyc = 0; res = 32'hDEAD_BEEF;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, result} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b result=%h, want 0 0 0", busy, done, result);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [31:0] res;
        int lat, bc;
        run_op(OP_DIVU, 32'd100, 32'd7, res, lat, bc);
        checks++;
        if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h want %h", res, 32'd14); end
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL divu_latency: got %0d want 34", lat); end
        checks++;
        if (bc !== 32) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 32", bc); end
        run_op(OP_REMU, 32'd100, 32'd7, res, lat, bc);
        checks++;
        if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h want %h", res, 32'd2); end
    endtask

    task automatic test_signed();
        logic [1:0]  ops [3] = '{OP_DIV, OP_REM, OP_REM};
        logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
        logic [31:0] want[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bc);
            checks++;
            if (res !== want[i] || res !== ref_div(ops[i], as[i], bs[i])) begin
                errors++;
                $display("FAIL signed_case%0d: got %h want %h", i, res, want[i]);
            end
            checks++;
            if (lat !== 34) begin errors++; $display("FAIL signed_latency%0d: got %0d want 34", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [5] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIV};
        logic [31:0] as  [5] = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FF00};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] want[5] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'd0, 32'hFFFF_FF00};
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bc);
            checks++;
            if (res !== want[i]) begin
                errors++;
                $display("FAIL special_case%0d: got %h want %h", i, res, want[i]);
            end
            checks++;
            if (lat !== exp_lat(ops[i], as[i], bs[i])) begin
                errors++;
                $display("FAIL special_latency%0d: got %0d want %0d", i, lat, exp_lat(ops[i], as[i], bs[i]));
            end
        end
    endtask

    task automatic test_kill();
        logic [31:0] prior, res;
        int lat, bc;
        bit saw_done, saw_busy;
        prior = result;
        op = OP_DIVU; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL kill_busy_before: got %0b want 1", busy); end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy_after: got %0b want 0", busy); end
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL kill_no_done: got done=1 want none"); end
        checks++;
        if (result !== prior) begin errors++; $display("FAIL kill_result_held: got %h want %h", result, prior); end
        @(posedge clk);
        #1;
        run_op(OP_DIVU, 32'd1000, 32'd10, res, lat, bc);
        checks++;
        if (res !== 32'd100 || lat !== 34) begin
            errors++;
            $display("FAIL kill_restart: got %h/%0d want %h/34", res, lat, 32'd100);
        end
        // start together with kill in IDLE must not be accepted
        op = OP_DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b0;
        saw_busy = 1'b0; saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_busy || saw_done) begin
            errors++;
            $display("FAIL start_with_kill: busy_seen=%0b done_seen=%0b want 0 0", saw_busy, saw_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_while_busy_and_rst();
        int lat;
        lat = 999;
        op = OP_DIVU; dividend = 32'd77777; divisor = 32'd13; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        op = OP_REMU; dividend = 32'd5; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 11; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
        checks++;
        if (lat !== 34 || result !== ref_div(OP_DIVU, 32'd77777, 32'd13)) begin
            errors++;
            $display("FAIL start_ignored: got %h lat %0d want %h lat 34", result, lat,
                     ref_div(OP_DIVU, 32'd77777, 32'd13));
        end
        @(posedge clk);
        #1;
        op = OP_DIVU; dividend = 32'd999; divisor = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result} !== 34'd0) begin
            errors++;
            $display("FAIL rst_midop: busy=%0b done=%0b result=%h want 0 0 0", busy, done, result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat, pulses;
        op = OP_DIVU; dividend = 32'd81; divisor = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 999;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
        checks++;
        if (lat !== 34 || result !== 32'd9) begin
            errors++;
            $display("FAIL b2b_first: got %h lat %0d want %h lat 34", result, lat, 32'd9);
        end
        op = OP_DIVU; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0; lat = 999;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (lat == 999) lat = c;
            end
        end
        checks++;
        if (pulses !== 1 || lat !== 34) begin
            errors++;
            $display("FAIL b2b_done_pulses: got %0d pulses lat %0d want 1 pulse lat 34", pulses, lat);
        end
        checks++;
        if (result !== 32'd3) begin errors++; $display("FAIL b2b_result: got %h want %h", result, 32'd3); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] a, b, res;
        logic [1:0]  o;
        int lat, bc;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (i % 6 == 0) a = 32'h8000_0000;
            run_op(o, a, b, res, lat, bc);
            checks++;
            if (res !== ref_div(o, a, b) || lat !== exp_lat(o, a, b)) begin
                errors++;
                $display("FAIL random%0d op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         i, o, a, b, res, lat, ref_div(o, a, b), exp_lat(o, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_kill();
        test_start_while_busy_and_rst();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
